rob_wb_unit: RTL
================

ROB_WB_UNIT -- requirements
Module: rob_wb_unit

Interface
REQ-001 SHALL have parameter LATENCY, default 3: cycles from issue acceptance to writeback visibility; legal values are 1 to 8.
REQ-002 SHALL have parameter WB_DEPTH, default 4: writeback FIFO entries and in-flight credit limit; legal values are 1 to 16.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_N_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port issue_in, input, rob_pkg::rob_issue: issue packet from the ROB; only valid and ptr are consumed.
REQ-006 SHALL have port exc_in, input, 1 bit: exception flag, qualified by issue_in.valid.
REQ-007 SHALL have port issue_ready_out, output, 1 bit: unit can accept an issue this cycle.
REQ-008 SHALL have port flush_in, input, 1 bit: pipeline flush (mispredict or exception).
REQ-009 SHALL have port wb_out, output, rob_pkg::rob_writeback: writeback packet to the ROB.
REQ-010 SHALL have port wb_ready_in, input, 1 bit: ROB accepts wb_out this cycle.

Function
REQ-011 SHALL accept an issue on a rising edge where issue_in.valid=1, issue_ready_out=1 and flush_in=0; in all other cases issue_in SHALL be ignored.
REQ-012 SHALL hold a LATENCY-stage shift register of {valid, ptr, exc}; stage 1 loads the accepted issue, or valid=0 if none; each stage advances every cycle unconditionally.
REQ-013 SHALL push the last stage into the writeback FIFO on the edge where the last stage holds valid=1.
REQ-014 SHALL, with an empty FIFO, assert wb_out.valid in cycle T+LATENCY for an issue accepted in cycle T.
REQ-015 SHALL drive wb_out from the FIFO head: valid = FIFO non-empty; ptr = head ptr; status = EXCEPTION if head exc=1, else DONE.
REQ-016 SHALL pop the FIFO head on an edge where wb_out.valid=1 and wb_ready_in=1; wb_out SHALL hold stable while valid=1 and wb_ready_in=0.
REQ-017 SHALL keep credit counter cnt (width $clog2(WB_DEPTH+1)) equal to valid pipeline stages plus FIFO occupancy.
REQ-018 SHALL update cnt per cycle as +1 on accept, -1 on pop, and unchanged when both occur.
REQ-019 SHALL drive issue_ready_out = (cnt < WB_DEPTH) && !flush_in, combinationally.
REQ-020 SHALL never overflow the FIFO; the credit rule guarantees a push never meets a full FIFO.
REQ-021 SHALL preserve issue order; writebacks leave in acceptance order.
REQ-022 SHALL implement FIFO pointers modulo WB_DEPTH with wrap-around, including non-power-of-two depths.
REQ-023 SHALL, on an edge where flush_in=1, clear all stage valids, empty the FIFO and set cnt=0; flush beats a simultaneous accept, push and pop (no pop handshake completes that cycle).
REQ-024 SHALL deassert wb_out.valid in the cycle after a flush edge.
REQ-025 SHALL handle push and pop on the same edge with a full FIFO: both occur and occupancy is unchanged.

Reset
REQ-026 SHALL, while rst_N_in=0, immediately and asynchronously clear all stage valids, FIFO pointers and cnt.
REQ-027 SHALL drive these reset output values: wb_out.valid=0, wb_out.ptr=0, wb_out.status=READY, issue_ready_out=1.
REQ-028 SHALL discard in-flight issues on reset asserted mid-operation; no writeback for them is ever produced after release.
REQ-029 SHALL allow accepting an issue on the first rising edge after rst_N_in deasserts.

Verification
REQ-030 Single issue: LATENCY=3, issue ptr=5, exc=0 accepted in cycle 10, wb_ready_in=1 -> wb_out {valid=1, ptr=5, DONE} in cycle 13 only.
REQ-031 Back-pressure: WB_DEPTH=4, issue ptrs 1..6 back-to-back, wb_ready_in=0 -> ready drops after 4 accepts; ptrs 1..4 held in order; raising wb_ready_in drains 1,2,3,4; ready returns.
REQ-032 Exception: issue ptr=127 with exc_in=1 -> wb_out {ptr=127, status=EXCEPTION}.
REQ-033 Flush: issue ptrs 7,8 accepted, flush_in=1 one cycle later with a simultaneous issue ptr=9 -> no writeback for 7, 8 or 9; cnt=0; next issue ptr=10 writes back normally.
REQ-034 Wrap and concurrency: WB_DEPTH=3, 20 issues with random wb_ready_in -> every ptr written back exactly once, in order; no loss across pointer wrap.
REQ-035 Mid-operation reset: assert rst_N_in=0 with 2 ops in the pipeline -> outputs take reset values immediately; no stale writeback after release.

Source files
------------

// File: rtl/rob_wb_unit.sv
`timescale 1ns/1ps
// rob_pkg: packet types shared between the ROB and its writeback unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package rob_pkg;
  localparam int PTR_W = 7;

  typedef enum logic [1:0] {
    READY     = 2'd0,
    DONE      = 2'd1,
    EXCEPTION = 2'd2
  } wb_status_e;

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] ptr;
  } rob_issue;

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] ptr;
    wb_status_e       status;
  } rob_writeback;
endpackage

// fifo: generic synchronous FIFO, modulo-DEPTH pointers (any DEPTH >= 1).
// Latency: a push is visible at head_dat the cycle after the push edge.
// Backpressure: none internally; the caller must never push into a full FIFO.
// Ports: clk/rst_n (async low), clr (sync empty, beats push/pop),
//        push/push_dat, pop, head_dat (head entry), empty.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [W-1:0]  mem [DEPTH];

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (occ == '0);
endmodule

// rob_wb_unit: fixed-latency execution model feeding a credit-limited writeback FIFO.
// Latency: issue accepted on edge T is presented on wb_out after edge T+LATENCY (FIFO empty).
// Backpressure: wb_ready_in stalls the FIFO; credits (pipeline + FIFO) gate issue_ready_out.
// Ports: clk_in, rst_N_in (async low), issue_in/exc_in/issue_ready_out (issue side),
//        flush_in (drops everything in flight), wb_out/wb_ready_in (writeback side).
module rob_wb_unit
  import rob_pkg::*;
#(
  parameter int LATENCY  = 3,
  parameter int WB_DEPTH = 4
) (
  input  logic         clk_in,
  input  logic         rst_N_in,
  input  rob_issue     issue_in,
  input  logic         exc_in,
  output logic         issue_ready_out,
  input  logic         flush_in,
  output rob_writeback wb_out,
  input  logic         wb_ready_in
);
  localparam int CW = $clog2(WB_DEPTH + 1);

  typedef struct packed {
    logic             vld;
    logic             exc;
    logic [PTR_W-1:0] ptr;
  } stage_t;

  stage_t          stg [LATENCY];
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            pop_hs;
  logic            fifo_empty;
  logic [PTR_W:0]  head_dat;

  // Credits cover every op from acceptance until its writeback is popped, so a
  // push can never find the FIFO full.
  assign issue_ready_out = (cnt < CW'(WB_DEPTH)) && !flush_in;
  assign accept          = issue_in.valid && issue_ready_out;
  assign pop_hs          = !fifo_empty && wb_ready_in && !flush_in;

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
    end else if (flush_in) begin
      for (int i = 0; i < LATENCY; i++) stg[i].vld <= 1'b0;
    end else begin
      stg[0] <= '{vld: accept, exc: exc_in, ptr: issue_in.ptr};
      for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      cnt <= '0;
    end else if (flush_in) begin
      cnt <= '0;
    end else begin
      case ({accept, pop_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Flush drives clr, which overrides the push from the last stage.
  fifo #(
    .W     (PTR_W + 1),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk      (clk_in),
    .rst_n    (rst_N_in),
    .clr      (flush_in),
    .push     (stg[LATENCY-1].vld),
    .push_dat ({stg[LATENCY-1].exc, stg[LATENCY-1].ptr}),
    .pop      (pop_hs),
    .head_dat (head_dat),
    .empty    (fifo_empty)
  );

  // Idle output is all zeros (ptr 0, READY) so reset and empty look identical.
  always_comb begin
    wb_out = '0;
    if (!fifo_empty) begin
      wb_out.valid  = 1'b1;
      wb_out.ptr    = head_dat[PTR_W-1:0];
      wb_out.status = head_dat[PTR_W] ? EXCEPTION : DONE;
    end
  end
endmodule
